// File: rtl/move_sequencer.sv
// Move sequencer: accepts one from/to request, pre-screens it, asks the legality checker,
// then clears the source and writes the destination square; owns turn, move count and game-over.
module move_sequencer #(
    parameter int unsigned CHECK_TIMEOUT = 16,
    parameter int unsigned MOVE_CNT_W    = 10
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [5:0]            i_req_from,
    input  logic [5:0]            i_req_to,
    input  logic [255:0]          i_board,
    output logic                  o_chk_req,
    output logic [5:0]            o_chk_from,
    output logic [5:0]            o_chk_to,
    input  logic                  i_chk_done,
    input  logic                  i_chk_allow,
    output logic                  o_wr_en,
    output logic [5:0]            o_wr_sq,
    output logic [3:0]            o_wr_piece,
    output logic                  o_turn,
    output logic                  o_move_done,
    output logic                  o_reject,
    output logic                  o_timeout,
    output logic [MOVE_CNT_W-1:0] o_move_count,
    output logic                  o_game_over,
    output logic                  o_winner
);

    localparam int unsigned CNT_W     = (CHECK_TIMEOUT > 1) ? $clog2(CHECK_TIMEOUT) : 1;
    localparam logic [2:0]  KING_TYPE = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WAIT, S_CLEAR, S_WRITE, S_COMMIT, S_REJECT, S_OVER
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [5:0]            r_from;
    logic [5:0]            r_to;
    logic [3:0]            r_mv_piece;
    logic [2:0]            r_cap_type;
    logic [CNT_W-1:0]      r_wait_cnt;

    logic                  r_req_ready;
    logic                  r_chk_req;
    logic                  r_wr_en;
    logic [5:0]            r_wr_sq;
    logic [3:0]            r_wr_piece;
    logic                  r_turn;
    logic                  r_move_done;
    logic                  r_reject;
    logic                  r_timeout;
    logic [MOVE_CNT_W-1:0] r_move_count;
    logic                  r_game_over;
    logic                  r_winner;

    logic [7:0]            w_from_idx;
    logic [7:0]            w_to_idx;
    logic [3:0]            w_src_piece;
    logic [3:0]            w_dst_piece;
    logic                  w_accept;
    logic                  w_bad_req;
    logic                  w_wait_expired;

    logic                  w_req_ready;
    logic                  w_chk_req;
    logic                  w_wr_en;
    logic [5:0]            w_wr_sq;
    logic [3:0]            w_wr_piece;
    logic                  w_turn;
    logic                  w_move_done;
    logic                  w_reject;
    logic                  w_timeout;
    logic [MOVE_CNT_W-1:0] w_move_count;
    logic                  w_game_over;
    logic                  w_winner;

    // Snapshot of the two squares involved, taken in the accept cycle
    assign w_from_idx     = {i_req_from, 2'b00};
    assign w_to_idx       = {i_req_to, 2'b00};
    assign w_src_piece    = i_board[w_from_idx +: 4];
    assign w_dst_piece    = i_board[w_to_idx +: 4];
    assign w_accept       = (r_state == S_IDLE) && i_req_valid && r_req_ready;
    assign w_bad_req      = (i_req_from == i_req_to) || (w_src_piece == 4'd0) ||
                            (w_src_piece[3] != r_turn);
    assign w_wait_expired = (r_wait_cnt == CNT_W'(CHECK_TIMEOUT - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = w_bad_req ? S_REJECT : S_CHECK;
            S_CHECK:  w_next_state = S_WAIT;
            S_WAIT: begin
                if (i_chk_done) begin
                    w_next_state = i_chk_allow ? S_CLEAR : S_REJECT;
                end else if (w_wait_expired) begin
                    w_next_state = S_REJECT;
                end
            end
            S_CLEAR:  w_next_state = S_WRITE;
            S_WRITE:  w_next_state = S_COMMIT;
            S_COMMIT: w_next_state = (r_cap_type == KING_TYPE) ? S_OVER : S_IDLE;
            S_REJECT: w_next_state = S_IDLE;
            S_OVER:   w_next_state = S_OVER;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output logic: values the output registers take for the upcoming state
    always_comb begin
        w_chk_req    = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_sq      = 6'd0;
        w_wr_piece   = 4'd0;
        w_move_done  = 1'b0;
        w_reject     = 1'b0;
        w_timeout    = 1'b0;
        w_turn       = r_turn;
        w_move_count = r_move_count;
        w_game_over  = r_game_over;
        w_winner     = r_winner;
        case (w_next_state)
            S_CHECK: w_chk_req = 1'b1;
            S_CLEAR: begin
                w_wr_en = 1'b1;
                w_wr_sq = r_from;
            end
            S_WRITE: begin
                w_wr_en    = 1'b1;
                w_wr_sq    = r_to;
                w_wr_piece = r_mv_piece;
            end
            S_COMMIT: begin
                w_move_done = 1'b1;
                w_turn      = ~r_turn;
                if (r_move_count != {MOVE_CNT_W{1'b1}}) begin
                    w_move_count = r_move_count + MOVE_CNT_W'(1);
                end
                if (r_cap_type == KING_TYPE) begin
                    w_game_over = 1'b1;
                    w_winner    = r_mv_piece[3];
                end
            end
            S_REJECT: begin
                w_reject  = 1'b1;
                w_timeout = (r_state == S_WAIT) && !i_chk_done;
            end
            default: ;
        endcase
        w_req_ready = (w_next_state == S_IDLE) && !w_game_over;
    end

    // Move latches, wait counter and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_from       <= 6'd0;
            r_to         <= 6'd0;
            r_mv_piece   <= 4'd0;
            r_cap_type   <= 3'd0;
            r_wait_cnt   <= '0;
            r_req_ready  <= 1'b1;
            r_chk_req    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_sq      <= 6'd0;
            r_wr_piece   <= 4'd0;
            r_turn       <= 1'b0;
            r_move_done  <= 1'b0;
            r_reject     <= 1'b0;
            r_timeout    <= 1'b0;
            r_move_count <= '0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_from     <= i_req_from;
                r_to       <= i_req_to;
                r_mv_piece <= w_src_piece;
                r_cap_type <= w_dst_piece[2:0];
            end
            if (r_state == S_CHECK) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            r_req_ready  <= w_req_ready;
            r_chk_req    <= w_chk_req;
            r_wr_en      <= w_wr_en;
            r_wr_sq      <= w_wr_sq;
            r_wr_piece   <= w_wr_piece;
            r_turn       <= w_turn;
            r_move_done  <= w_move_done;
            r_reject     <= w_reject;
            r_timeout    <= w_timeout;
            r_move_count <= w_move_count;
            r_game_over  <= w_game_over;
            r_winner     <= w_winner;
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_chk_req    = r_chk_req;
    assign o_chk_from   = r_from;
    assign o_chk_to     = r_to;
    assign o_wr_en      = r_wr_en;
    assign o_wr_sq      = r_wr_sq;
    assign o_wr_piece   = r_wr_piece;
    assign o_turn       = r_turn;
    assign o_move_done  = r_move_done;
    assign o_reject     = r_reject;
    assign o_timeout    = r_timeout;
    assign o_move_count = r_move_count;
    assign o_game_over  = r_game_over;
    assign o_winner     = r_winner;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: legal moves, pre-screen and checker rejects,
// checker timeout, king capture and reset in mid-move.
module tb_move_sequencer;

    logic         clk;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [5:0]   req_from;
    logic [5:0]   req_to;
    logic [255:0] board;
    logic         chk_req;
    logic [5:0]   chk_from;
    logic [5:0]   chk_to;
    logic         chk_done;
    logic         chk_allow;
    logic         wr_en;
    logic [5:0]   wr_sq;
    logic [3:0]   wr_piece;
    logic         turn;
    logic         move_done;
    logic         reject;
    logic         timeout;
    logic [9:0]   move_count;
    logic         game_over;
    logic         winner;

    int n_total = 0;
    int n_bad   = 0;
    int wr_pulses = 0;

    move_sequencer #(.CHECK_TIMEOUT(16), .MOVE_CNT_W(10)) dut (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_from(req_from), .i_req_to(req_to), .i_board(board),
        .o_chk_req(chk_req), .o_chk_from(chk_from), .o_chk_to(chk_to),
        .i_chk_done(chk_done), .i_chk_allow(chk_allow),
        .o_wr_en(wr_en), .o_wr_sq(wr_sq), .o_wr_piece(wr_piece),
        .o_turn(turn), .o_move_done(move_done), .o_reject(reject), .o_timeout(timeout),
        .o_move_count(move_count), .o_game_over(game_over), .o_winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample just after the edge; strobes must never overlap
    task automatic step();
        int n_str;
        @(posedge clk);
        #1;
        n_str = int'(wr_en) + int'(chk_req) + int'(move_done) + int'(reject);
        check_eq("strobe_excl", 32'(n_str <= 1), 32'd1);
        if (wr_en) wr_pulses++;
    endtask

    task automatic set_sq(input int s, input logic [3:0] v);
        board[4*s +: 4] = v;
    endtask

    task automatic legal_move(input logic [5:0] f, input logic [5:0] t, input int k,
                              input logic [3:0] piece, input logic exp_over);
        req_from = f; req_to = t; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check_eq("chk_req_pulse", 32'(chk_req), 32'd1);
        check_eq("busy_ready", 32'(req_ready), 32'd0);
        check_eq("chk_from", 32'(chk_from), 32'(f));
        check_eq("chk_to", 32'(chk_to), 32'(t));
        for (int i = 0; i <= k; i++) begin
            step();
            check_eq("wait_no_req", 32'(chk_req), 32'd0);
            check_eq("wait_no_wr", 32'(wr_en), 32'd0);
            chk_done  = (i == k);
            chk_allow = 1'b1;
        end
        step();
        chk_done = 1'b0;
        check_eq("clr_en", 32'(wr_en), 32'd1);
        check_eq("clr_sq", 32'(wr_sq), 32'(f));
        check_eq("clr_piece", 32'(wr_piece), 32'd0);
        step();
        check_eq("wr_en", 32'(wr_en), 32'd1);
        check_eq("wr_sq", 32'(wr_sq), 32'(t));
        check_eq("wr_piece", 32'(wr_piece), 32'(piece));
        step();
        check_eq("commit_done", 32'(move_done), 32'd1);
        check_eq("commit_no_wr", 32'(wr_en), 32'd0);
        step();
        check_eq("after_done", 32'(move_done), 32'd0);
        check_eq("after_ready", 32'(req_ready), 32'(!exp_over));
        set_sq(int'(f), 4'h0);
        set_sq(int'(t), piece);
    endtask

    task automatic screen_reject(input string tag, input logic [5:0] f, input logic [5:0] t);
        int w0;
        w0 = wr_pulses;
        req_from = f; req_to = t; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check_eq({tag, "_rej"}, 32'(reject), 32'd1);
        check_eq({tag, "_to"}, 32'(timeout), 32'd0);
        check_eq({tag, "_nochk"}, 32'(chk_req), 32'd0);
        step();
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_nowr"}, 32'(wr_pulses), 32'(w0));
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int w0;
        reset = 1'b1; req_valid = 1'b0; req_from = '0; req_to = '0;
        chk_done = 1'b0; chk_allow = 1'b0; board = '0;
        set_sq(12, 4'h1);
        set_sq(52, 4'h9);
        set_sq(60, 4'hE);
        set_sq(3,  4'h5);
        step();
        step();
        reset = 1'b0;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_turn", 32'(turn), 32'd0);
        check_eq("rst_count", 32'(move_count), 32'd0);
        check_eq("rst_over", 32'(game_over), 32'd0);
        check_eq("rst_wr", 32'(wr_en), 32'd0);

        // White pawn 12->28, checker answers 3 cycles after chk_req
        legal_move(6'd12, 6'd28, 2, 4'h1, 1'b0);
        check_eq("m1_turn", 32'(turn), 32'd1);
        check_eq("m1_count", 32'(move_count), 32'd1);

        screen_reject("colour", 6'd28, 6'd36);
        screen_reject("same", 6'd52, 6'd52);
        screen_reject("empty", 6'd20, 6'd30);
        check_eq("scr_turn", 32'(turn), 32'd1);

        // Checker refuses
        w0 = wr_pulses;
        req_from = 6'd52; req_to = 6'd36; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk_done = 1'b1; chk_allow = 1'b0;
        step();
        chk_done = 1'b0;
        check_eq("deny_rej", 32'(reject), 32'd1);
        check_eq("deny_to", 32'(timeout), 32'd0);
        step();
        check_eq("deny_ready", 32'(req_ready), 32'd1);
        check_eq("deny_turn", 32'(turn), 32'd1);
        check_eq("deny_nowr", 32'(wr_pulses), 32'(w0));

        // Checker silent: reject on the 17th cycle after CHECK
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check_eq("to_chk_req", 32'(chk_req), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step();
            check_eq("to_waiting", 32'(reject), 32'd0);
        end
        step();
        check_eq("to_rej", 32'(reject), 32'd1);
        check_eq("to_flag", 32'(timeout), 32'd1);
        step();
        check_eq("to_ready", 32'(req_ready), 32'd1);
        check_eq("to_nowr", 32'(wr_pulses), 32'(w0));

        // Done arrives on the last allowed WAIT cycle: still commits
        legal_move(6'd52, 6'd44, 15, 4'h9, 1'b0);
        check_eq("m2_turn", 32'(turn), 32'd0);
        check_eq("m2_count", 32'(move_count), 32'd2);

        // White queen takes black king
        legal_move(6'd3, 6'd60, 0, 4'h5, 1'b1);
        check_eq("ko_over", 32'(game_over), 32'd1);
        check_eq("ko_winner", 32'(winner), 32'd0);
        check_eq("ko_count", 32'(move_count), 32'd3);
        w0 = wr_pulses;
        req_from = 6'd44; req_to = 6'd36; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("over_ready", 32'(req_ready), 32'd0);
            check_eq("over_nochk", 32'(chk_req), 32'd0);
            check_eq("over_norej", 32'(reject), 32'd0);
        end
        req_valid = 1'b0;
        check_eq("over_nowr", 32'(wr_pulses), 32'(w0));

        // Reset during WAIT
        reset_dut();
        check_eq("rst2_over", 32'(game_over), 32'd0);
        set_sq(12, 4'h1);
        req_from = 6'd12; req_to = 6'd28; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rw_ready", 32'(req_ready), 32'd1);
        check_eq("rw_turn", 32'(turn), 32'd0);
        check_eq("rw_count", 32'(move_count), 32'd0);
        w0 = wr_pulses;
        for (int i = 0; i < 20; i++) step();
        check_eq("rw_nowr", 32'(wr_pulses), 32'(w0));

        // Reset during CLEAR: the WRITE must never happen
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk_done = 1'b1; chk_allow = 1'b1;
        step();
        chk_done = 1'b0;
        check_eq("rc_clear", 32'(wr_en), 32'd1);
        w0 = wr_pulses;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rc_wr", 32'(wr_en), 32'd0);
        check_eq("rc_ready", 32'(req_ready), 32'd1);
        check_eq("rc_turn", 32'(turn), 32'd0);
        check_eq("rc_count", 32'(move_count), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check_eq("rc_nowr", 32'(wr_pulses), 32'(w0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
